sakebi_gray_codec: RTL and testbench

Registered, parameterizable binary/Gray code converter. Two independent lanes: binary→Gray (`bin2gray`) and Gray→binary (`gray2bin`). Each lane has a valid strobe and a fixed one-cycle latency. It sits next to multi-bit pointers that cross clock domains, such as async FIFO read/write pointers and counters, where values must change by one bit per step.

---
 rtl/sakebi_gray_pkg.sv | 52 +++++
 rtl/sakebi_gray_adj_check.sv | 49 ++++
 rtl/sakebi_gray_codec.sv | 83 ++++++++
 tb/tb_sakebi_gray_codec.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sakebi_gray_pkg.sv
// sakebi_gray_pkg: shared helpers for the binary/Gray codec.
// Conversions work on a MAX_WIDTH container and mask down to the
// requested width, so one function body serves every WIDTH instance.
package sakebi_gray_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] word_t;

    // Mask selecting the low 'width' bits of a container word.
    function automatic word_t width_mask(input int unsigned width);
        word_t mask;
        if (width >= MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (word_t'(1) << width) - word_t'(1);
        end
        return mask;
    endfunction

    // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
    function automatic word_t bin2gray(input word_t bin, input int unsigned width);
        word_t b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR from the MSB downwards. Bits above the
    // active width are masked to zero, so they never disturb the result.
    function automatic word_t gray2bin(input word_t gray, input int unsigned width);
        word_t g;
        word_t b;
        g = gray & width_mask(width);
        b = '0;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Number of set bits in a container word.
    function automatic logic [5:0] popcount(input word_t value);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + 6'(value[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sakebi_gray_adj_check.sv
// sakebi_gray_adj_check: flags Gray inputs that change by more than one
// bit relative to the previous valid input. The first valid value after
// reset only seeds the history and never flags.
module sakebi_gray_adj_check
    import sakebi_gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_gray,
    input  logic             i_gray_valid,
    output logic             o_err
);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] diff;

    // History update and single-cycle error pulse, aligned with the decode lane.
    always_comb begin
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        err_d       = 1'b0;
        diff        = i_gray ^ prev_q;
        if (i_gray_valid) begin
            prev_d      = i_gray;
            have_prev_d = 1'b1;
            err_d       = have_prev_q && (popcount(word_t'(diff)) > 6'd1);
        end
    end

    // State registers; reset clears history so the next value is trusted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            err_q       <= err_d;
        end
    end

    assign o_err = err_q;

endmodule

// File: rtl/sakebi_gray_codec.sv
// sakebi_gray_codec: registered binary->Gray and Gray->binary lanes with
// one-cycle latency each. Data registers hold on idle cycles; only the
// valid outputs drop.
// Optional feature macro: SAKEBI_GRAY_ADJ_CHECK_EN adds o_gray_adj_err,
// which pulses when a valid Gray input differs from the previous one in
// more than one bit.
module sakebi_gray_codec
    import sakebi_gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_bin,
    input  logic             i_bin_valid,
    output logic [WIDTH-1:0] o_gray,
    output logic             o_gray_valid,
    input  logic [WIDTH-1:0] i_gray,
    input  logic             i_gray_valid,
    output logic [WIDTH-1:0] o_bin,
    output logic             o_bin_valid
`ifdef SAKEBI_GRAY_ADJ_CHECK_EN
    ,
    output logic             o_gray_adj_err
`endif
);

    logic [WIDTH-1:0] gray_q, gray_d;
    logic             gray_valid_q, gray_valid_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             bin_valid_q, bin_valid_d;

    // Encode lane next state: load on valid, otherwise hold the last code.
    always_comb begin
        gray_d       = gray_q;
        gray_valid_d = i_bin_valid;
        if (i_bin_valid) begin
            gray_d = WIDTH'(bin2gray(word_t'(i_bin), WIDTH));
        end
    end

    // Decode lane next state: load on valid, otherwise hold the last value.
    always_comb begin
        bin_d       = bin_q;
        bin_valid_d = i_gray_valid;
        if (i_gray_valid) begin
            bin_d = WIDTH'(gray2bin(word_t'(i_gray), WIDTH));
        end
    end

    // Output registers for both lanes; reset wins over any incoming valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gray_q       <= '0;
            gray_valid_q <= 1'b0;
            bin_q        <= '0;
            bin_valid_q  <= 1'b0;
        end else begin
            gray_q       <= gray_d;
            gray_valid_q <= gray_valid_d;
            bin_q        <= bin_d;
            bin_valid_q  <= bin_valid_d;
        end
    end

    assign o_gray       = gray_q;
    assign o_gray_valid = gray_valid_q;
    assign o_bin        = bin_q;
    assign o_bin_valid  = bin_valid_q;

`ifdef SAKEBI_GRAY_ADJ_CHECK_EN
    sakebi_gray_adj_check #(
        .WIDTH(WIDTH)
    ) u_adj_check (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_gray       (i_gray),
        .i_gray_valid (i_gray_valid),
        .o_err        (o_gray_adj_err)
    );
`endif

endmodule

// File: tb/tb_sakebi_gray_codec.sv
// tb_sakebi_gray_codec: directed-vector bench for the Gray codec, with a
// WIDTH=4 instance for the main checks and a WIDTH=8 instance for the
// wide spot check. Adjacency checks build only with SAKEBI_GRAY_ADJ_CHECK_EN.
module tb_sakebi_gray_codec;

    logic       clk;
    logic       rst;
    logic [3:0] bin_in;
    logic       bin_valid_in;
    logic [3:0] gray_out;
    logic       gray_valid_out;
    logic [3:0] gray_in;
    logic       gray_valid_in;
    logic [3:0] bin_out;
    logic       bin_valid_out;
    logic       adj_err;

    logic [7:0] bin8_in;
    logic       bin8_valid_in;
    logic [7:0] gray8_out;
    logic       gray8_valid_out;
    logic [7:0] gray8_in;
    logic       gray8_valid_in;
    logic [7:0] bin8_out;
    logic       bin8_valid_out;
    logic       adj8_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    sakebi_gray_codec #(.WIDTH(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_bin          (bin_in),
        .i_bin_valid    (bin_valid_in),
        .o_gray         (gray_out),
        .o_gray_valid   (gray_valid_out),
        .i_gray         (gray_in),
        .i_gray_valid   (gray_valid_in),
        .o_bin          (bin_out),
        .o_bin_valid    (bin_valid_out)
`ifdef SAKEBI_GRAY_ADJ_CHECK_EN
        ,
        .o_gray_adj_err (adj_err)
`endif
    );

    sakebi_gray_codec #(.WIDTH(8)) dut8 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_bin          (bin8_in),
        .i_bin_valid    (bin8_valid_in),
        .o_gray         (gray8_out),
        .o_gray_valid   (gray8_valid_out),
        .i_gray         (gray8_in),
        .i_gray_valid   (gray8_valid_in),
        .o_bin          (bin8_out),
        .o_bin_valid    (bin8_valid_out)
`ifdef SAKEBI_GRAY_ADJ_CHECK_EN
        ,
        .o_gray_adj_err (adj8_err)
`endif
    );

`ifndef SAKEBI_GRAY_ADJ_CHECK_EN
    assign adj_err  = 1'b0;
    assign adj8_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, act);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bin_in = '0; bin_valid_in = 1'b0; gray_in = '0; gray_valid_in = 1'b0;
        bin8_in = '0; bin8_valid_in = 1'b0; gray8_in = '0; gray8_valid_in = 1'b0;
        step();
        step();

        // Reset state
        check("rst_gray", 32'(gray_out), 32'h0);
        check("rst_gray_valid", 32'(gray_valid_out), 32'h0);
        check("rst_bin", 32'(bin_out), 32'h0);
        check("rst_bin_valid", 32'(bin_valid_out), 32'h0);
        check("rst_adj_err", 32'(adj_err), 32'h0);
        rst = 1'b0;

        // Encode sweep 0..F
        for (int i = 0; i < 16; i++) begin
            bin_in = 4'(i);
            bin_valid_in = 1'b1;
            step();
            check($sformatf("enc_%0h", i), 32'(gray_out), 32'(gray_tab[i]));
            check($sformatf("enc_valid_%0h", i), 32'(gray_valid_out), 32'h1);
        end
        bin_valid_in = 1'b0;
        step();

        // Round trip: loop the encoder output back into the decoder
        for (int i = 0; i <= 16; i++) begin
            bin_in = 4'(i);
            bin_valid_in = (i < 16);
            gray_in = gray_out;
            gray_valid_in = (i > 0);
            step();
            if (i > 0) begin
                check($sformatf("rt_%0h", i - 1), 32'(bin_out), 32'(i - 1));
                check($sformatf("rt_valid_%0h", i - 1), 32'(bin_valid_out), 32'h1);
`ifdef SAKEBI_GRAY_ADJ_CHECK_EN
                check($sformatf("rt_adj_%0h", i - 1), 32'(adj_err), 32'h0);
`endif
            end
        end
        bin_valid_in = 1'b0;
        gray_valid_in = 1'b0;
        step();

        // Hold during a valid gap
        bin_in = 4'h5;
        bin_valid_in = 1'b1;
        step();
        check("hold_load", 32'(gray_out), 32'h7);
        bin_in = 4'hA;
        bin_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_gray_%0d", i), 32'(gray_out), 32'h7);
            check($sformatf("hold_valid_%0d", i), 32'(gray_valid_out), 32'h0);
        end

        // Reset in the middle of a stream on both lanes
        bin_in = 4'h3; bin_valid_in = 1'b1;
        gray_in = 4'h2; gray_valid_in = 1'b1;
        step();
        check("pre_rst_gray", 32'(gray_out), 32'h2);
        check("pre_rst_bin", 32'(bin_out), 32'h3);
        rst = 1'b1;
        bin_in = 4'h6; gray_in = 4'h5;
        step();
        check("mid_rst_gray", 32'(gray_out), 32'h0);
        check("mid_rst_gray_valid", 32'(gray_valid_out), 32'h0);
        check("mid_rst_bin", 32'(bin_out), 32'h0);
        check("mid_rst_bin_valid", 32'(bin_valid_out), 32'h0);
        check("mid_rst_adj", 32'(adj_err), 32'h0);
        rst = 1'b0;
        bin_in = 4'h9; gray_in = 4'hD;
        step();
        check("post_rst_gray", 32'(gray_out), 32'hD);
        check("post_rst_gray_valid", 32'(gray_valid_out), 32'h1);
        check("post_rst_bin", 32'(bin_out), 32'h9);
        check("post_rst_bin_valid", 32'(bin_valid_out), 32'h1);
        check("post_rst_adj_first", 32'(adj_err), 32'h0);
        bin_valid_in = 1'b0;
        gray_valid_in = 1'b0;
        step();

`ifdef SAKEBI_GRAY_ADJ_CHECK_EN
        // Adjacency: 0,1,3,3,5 then 8 (3 bits from 5) then wrap 8->0
        rst = 1'b1;
        step();
        rst = 1'b0;
        begin
            logic [3:0] adj_seq [7] = '{4'h0, 4'h1, 4'h3, 4'h3, 4'h5, 4'h8, 4'h0};
            logic       adj_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 7; i++) begin
                gray_in = adj_seq[i];
                gray_valid_in = 1'b1;
                step();
                check($sformatf("adj_%0d_%0h", i, adj_seq[i]), 32'(adj_err), 32'(adj_exp[i]));
            end
        end
        gray_in = 4'hF;
        gray_valid_in = 1'b0;
        step();
        check("adj_idle", 32'(adj_err), 32'h0);
`endif

        // WIDTH=8 spot checks
        bin8_in = 8'hFF; bin8_valid_in = 1'b1;
        gray8_in = 8'h80; gray8_valid_in = 1'b1;
        step();
        check("w8_enc_ff", 32'(gray8_out), 32'h80);
        check("w8_dec_80", 32'(bin8_out), 32'hFF);
        bin8_in = 8'hA5;
        gray8_in = 8'hC0;
        step();
        check("w8_enc_a5", 32'(gray8_out), 32'hF7);
        check("w8_dec_c0", 32'(bin8_out), 32'h80);
        check("w8_valid", 32'(gray8_valid_out & bin8_valid_out), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
